flunky_apb_mem: RTL and testbench

Parametrised APB4 slave memory with a second native port. The APB side gives the host configurable-width, byte-strobed, wait-state-programmable access to on-chip SRAM. The native port gives the core single-cycle access to the same array. It replaces the fixed 32-bit, zero-wait, write-always APB RAM wrapper in the flunkyfive top level.

---
 rtl/flunky_apb_mem.sv | 172 +++++++++++++++++
 tb/tb_flunky_apb_mem.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flunky_apb_mem.sv
`default_nettype none
// ============================================================================
// flunky_apb_mem: APB4 slave SRAM with a second single-cycle native port.
// Optional macro FLUNKY_APB_MEM_SLVERR_EN: out-of-range index -> SLVERR.
// Revision: 1.0
// ============================================================================
module flunky_apb_mem #(
  parameter  int DATA_WIDTH  = 32,
  parameter  int ADDR_WIDTH  = 16,
  parameter  int MEM_WORDS   = 16384,
  parameter  int WAIT_STATES = 0,
  localparam int SW          = DATA_WIDTH / 8,
  localparam int IW          = $clog2(MEM_WORDS)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [SW-1:0]         pstrb,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  input  logic                  b_en,
  input  logic                  b_we,
  input  logic [SW-1:0]         b_be,
  input  logic [IW-1:0]         b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  b_rvalid,
  output logic                  b_collision
);

  localparam int         c_SHIFT = $clog2(SW);
  localparam logic [2:0] c_WAIT  = 3'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1
`ifdef FLUNKY_APB_MEM_SLVERR_EN
    , S_ERRACC = 2'd2
`endif
  } state_t;

  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

  state_t                r_state;
  state_t                w_next;
  logic [2:0]            r_cnt;
  logic [IW-1:0]         r_idx;
  logic                  r_write;
  logic [SW-1:0]         r_strb;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic [DATA_WIDTH-1:0] r_b_rdata;
  logic                  r_b_rvalid;
  logic                  r_b_coll;

  logic [ADDR_WIDTH-1:0] w_word;
  logic [IW-1:0]         w_idx;
  logic                  w_setup;
  logic                  w_done;
  logic                  w_apb_we;
  logic                  w_b_we;
  logic                  w_collide;
  logic                  w_unused;

  assign w_word   = paddr >> c_SHIFT;
  assign w_idx    = w_word[IW-1:0];
  assign w_unused = ^{paddr, w_word};

`ifdef FLUNKY_APB_MEM_SLVERR_EN
  logic w_in_range;
  assign w_in_range = (64'(w_word) < 64'(MEM_WORDS));
`endif

  assign w_setup   = (r_state == S_IDLE) && psel && !penable;
  assign w_done    = (r_cnt == 3'd0);
  assign w_apb_we  = (r_state == S_ACCESS) && psel && w_done && r_write;
  assign w_b_we    = b_en && b_we;
  // Same-word write from both ports: APB takes priority.
  assign w_collide = w_apb_we && w_b_we && (b_addr == r_idx);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    pready  = 1'b0;
    pslverr = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_setup) begin
`ifdef FLUNKY_APB_MEM_SLVERR_EN
          if (w_in_range) w_next = S_ACCESS;
          else            w_next = S_ERRACC;
`else
          w_next = S_ACCESS;
`endif
        end
      end
      S_ACCESS: begin
        pready = w_done;
        if (!psel || w_done) w_next = S_IDLE;
      end
`ifdef FLUNKY_APB_MEM_SLVERR_EN
      S_ERRACC: begin
        pready  = w_done;
        pslverr = w_done;
        if (!psel || w_done) w_next = S_IDLE;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // Transfer context is captured at SETUP so the RAM read uses the old word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt    <= 3'd0;
      r_idx    <= '0;
      r_write  <= 1'b0;
      r_strb   <= '0;
      r_wdata  <= '0;
      r_prdata <= '0;
    end else if (w_setup) begin
      r_cnt   <= c_WAIT;
      r_idx   <= w_idx;
      r_write <= pwrite;
      r_strb  <= pstrb;
      r_wdata <= pwdata;
      if (!pwrite) r_prdata <= r_mem[w_idx];
`ifdef FLUNKY_APB_MEM_SLVERR_EN
      if (!w_in_range) r_prdata <= '0;
`endif
    end else if ((r_state != S_IDLE) && !w_done) begin
      r_cnt <= r_cnt - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_b_rdata  <= '0;
      r_b_rvalid <= 1'b0;
      r_b_coll   <= 1'b0;
    end else begin
      r_b_rvalid <= b_en && !b_we;
      r_b_coll   <= w_collide;
      if (b_en && !b_we) r_b_rdata <= r_mem[b_addr];
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < SW; k++) begin
      if (w_b_we && !w_collide && b_be[k])
        r_mem[b_addr][8*k +: 8] <= b_wdata[8*k +: 8];
      if (w_apb_we && r_strb[k])
        r_mem[r_idx][8*k +: 8] <= r_wdata[8*k +: 8];
    end
  end

  assign prdata      = r_prdata;
  assign b_rdata     = r_b_rdata;
  assign b_rvalid    = r_b_rvalid;
  assign b_collision = r_b_coll;

endmodule
`default_nettype wire

// File: tb/tb_flunky_apb_mem.sv
`default_nettype none
// ============================================================================
// tb_flunky_apb_mem: directed bench driving three instances (0/3 wait states,
// 16K words, plus a 1K-word copy) with shared APB and native stimulus.
// Revision: 1.0
// ============================================================================
module tb_flunky_apb_mem;

  logic        clk     = 1'b0;
  logic        resetn  = 1'b1;
  logic [15:0] paddr   = '0;
  logic        psel    = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite  = 1'b0;
  logic [3:0]  pstrb   = '0;
  logic [31:0] pwdata  = '0;
  logic        b_en    = 1'b0;
  logic        b_we    = 1'b0;
  logic [3:0]  b_be    = '0;
  logic [13:0] b_addr  = '0;
  logic [31:0] b_wdata = '0;

  logic [31:0] prdata0, prdata3, prdatak, b_rdata0, b_rdata3, b_rdatak;
  logic        pready0, pready3, preadyk, pslverr0, pslverr3, pslverrk;
  logic        b_rvalid0, b_rvalid3, b_rvalidk, b_coll0, b_coll3, b_collk;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd0, rd3, rdk;
  logic        e0, e3, ek;
  int          lo3, rdy0, rdyk, c0, c3;

  always #5 clk = ~clk;

  flunky_apb_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_WORDS(16384), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .resetn(resetn), .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pstrb(pstrb), .pwdata(pwdata), .prdata(prdata0), .pready(pready0), .pslverr(pslverr0),
    .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata0), .b_rvalid(b_rvalid0), .b_collision(b_coll0));

  flunky_apb_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_WORDS(16384), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .resetn(resetn), .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pstrb(pstrb), .pwdata(pwdata), .prdata(prdata3), .pready(pready3), .pslverr(pslverr3),
    .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata3), .b_rvalid(b_rvalid3), .b_collision(b_coll3));

  flunky_apb_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_WORDS(1024), .WAIT_STATES(0)) u_w1k (
    .clk(clk), .resetn(resetn), .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pstrb(pstrb), .pwdata(pwdata), .prdata(prdatak), .pready(preadyk), .pslverr(pslverrk),
    .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr[9:0]), .b_wdata(b_wdata),
    .b_rdata(b_rdatak), .b_rvalid(b_rvalidk), .b_collision(b_collk));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic nat_wr(input logic [13:0] a, input logic [3:0] be, input logic [31:0] d);
    b_en = 1'b1; b_we = 1'b1; b_addr = a; b_be = be; b_wdata = d;
  endtask

  task automatic nat_clr();
    b_en = 1'b0; b_we = 1'b0; b_be = '0;
  endtask

  task automatic sample();
    rdy0 += int'(pready0);
    rdyk += int'(preadyk);
    c0   += int'(b_coll0);
    c3   += int'(b_coll3);
  endtask

  // nat_at: 0 none, 1 native write in SETUP, 2 in first ACCESS, 3 in the 3-wait completion cycle.
  task automatic apb(input logic [15:0] a, input logic wr, input logic [3:0] st,
                     input logic [31:0] wd, input int nat_at,
                     input logic [13:0] na, input logic [31:0] nd);
    rdy0 = 0; rdyk = 0; c0 = 0; c3 = 0; lo3 = 0;
    paddr = a; pwrite = wr; pstrb = st; pwdata = wd; psel = 1'b1; penable = 1'b0;
    if (nat_at == 1) nat_wr(na, 4'hF, nd);
    @(posedge clk); #1;
    nat_clr();
    penable = 1'b1;
    rd0 = prdata0; e0 = pslverr0;
    rdk = prdatak; ek = pslverrk;
    sample();
    if (nat_at == 2) nat_wr(na, 4'hF, nd);
    while (!pready3 && lo3 < 12) begin
      lo3++;
      @(posedge clk); #1;
      nat_clr();
      sample();
    end
    rd3 = prdata3; e3 = pslverr3;
    if (nat_at == 3) nat_wr(na, 4'hF, nd);
    @(posedge clk); #1;
    nat_clr();
    psel = 1'b0; penable = 1'b0;
    sample();
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] st);
    apb(a, 1'b1, st, d, 0, 14'd0, 32'd0);
  endtask

  task automatic rd(input logic [15:0] a);
    apb(a, 1'b0, 4'h0, 32'd0, 0, 14'd0, 32'd0);
  endtask

  task automatic nat_read(input logic [13:0] a);
    b_en = 1'b1; b_we = 1'b0; b_addr = a;
    @(posedge clk); #1;
    nat_clr();
  endtask

  initial begin
    #2 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl0", 32'({pready0, pslverr0, b_rvalid0, b_coll0}), 32'd0);
    chk("rst_ctrl3", 32'({pready3, pslverr3, b_rvalid3, b_coll3}), 32'd0);
    chk("rst_prdata0", prdata0, 32'd0);
    chk("rst_b_rdata0", b_rdata0, 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Full-word write and readback
    wr(16'h0010, 32'hDEADBEEF, 4'hF);
    chk("t1_wr_rdy0", 32'(rdy0), 32'd1);
    chk("t1_wr_lo3", 32'(lo3), 32'd3);
    chk("t1_wr_err", 32'({e0, e3}), 32'd0);
    rd(16'h0010);
    chk("t1_rd0", rd0, 32'hDEADBEEF);
    chk("t1_rd3", rd3, 32'hDEADBEEF);
    chk("t1_rdk", rdk, 32'hDEADBEEF);
    chk("t1_rd_rdy0", 32'(rdy0), 32'd1);

    // Byte strobes, back-to-back transfers
    wr(16'h0020, 32'h11223344, 4'hF);
    wr(16'h0020, 32'h0000AB00, 4'h2);
    chk("t2_wr_lo3", 32'(lo3), 32'd3);
    rd(16'h0020);
    chk("t2_rd0", rd0, 32'h1122AB44);
    chk("t2_rd3", rd3, 32'h1122AB44);

    // Native write, APB readback, native read pulse
    nat_wr(14'd5, 4'hF, 32'hCAFEF00D);
    @(posedge clk); #1;
    nat_clr();
    rd(16'h0014);
    chk("t3_rd0", rd0, 32'hCAFEF00D);
    chk("t3_rd3", rd3, 32'hCAFEF00D);
    nat_read(14'd5);
    chk("t3_rvalid", 32'({b_rvalid0, b_rvalid3}), 32'h3);
    chk("t3_b_rdata0", b_rdata0, 32'hCAFEF00D);
    @(posedge clk); #1;
    chk("t3_rvalid_pulse", 32'({b_rvalid0, b_rvalid3}), 32'h0);

    // Native byte enables
    nat_wr(14'd6, 4'hF, 32'hFFFFFFFF);
    @(posedge clk); #1;
    nat_wr(14'd6, 4'h9, 32'h11223344);
    @(posedge clk); #1;
    nat_clr();
    nat_read(14'd6);
    chk("nat_be", b_rdata3, 32'h11FFFF44);

    // Cross-port read-during-write returns old data
    apb(16'h0014, 1'b0, 4'h0, 32'd0, 1, 14'd5, 32'h12345678);
    chk("rdw_rd0", rd0, 32'hCAFEF00D);
    chk("rdw_rd3", rd3, 32'hCAFEF00D);
    nat_read(14'd5);
    chk("rdw_after", b_rdata0, 32'h12345678);

    // Collision on the 0-wait instance
    apb(16'h001C, 1'b1, 4'hF, 32'h1, 2, 14'd7, 32'h2);
    chk("t4a_coll0", 32'(c0), 32'd1);
    chk("t4a_coll3", 32'(c3), 32'd0);
    rd(16'h001C);
    chk("t4a_rd0", rd0, 32'h1);
    chk("t4a_rd3", rd3, 32'h1);

    // Collision on the 3-wait instance
    apb(16'h001C, 1'b1, 4'hF, 32'h3, 3, 14'd7, 32'h4);
    chk("t4b_coll3", 32'(c3), 32'd1);
    chk("t4b_coll0", 32'(c0), 32'd0);
    @(posedge clk); #1;
    chk("t4b_coll3_pulse", 32'(b_coll3), 32'd0);
    rd(16'h001C);
    chk("t4b_rd3", rd3, 32'h3);
    chk("t4b_rd0", rd0, 32'h4);

    // Out-of-range index on the 1K-word instance
    wr(16'h0000, 32'h0BADF00D, 4'hF);
    wr(16'h1000, 32'hA5A5A5A5, 4'hF);
`ifdef FLUNKY_APB_MEM_SLVERR_EN
    chk("t5_wr_errk", 32'(ek), 32'd1);
`else
    chk("t5_wr_errk", 32'(ek), 32'd0);
`endif
    chk("t5_wr_rdyk", 32'(rdyk), 32'd1);
    rd(16'h0000);
    chk("t5_rd0_w0", rd0, 32'h0BADF00D);
`ifdef FLUNKY_APB_MEM_SLVERR_EN
    chk("t5_rdk_w0", rdk, 32'h0BADF00D);
`else
    chk("t5_rdk_w0", rdk, 32'hA5A5A5A5);
`endif
    rd(16'h1000);
    chk("t5_rd0_hi", rd0, 32'hA5A5A5A5);
`ifdef FLUNKY_APB_MEM_SLVERR_EN
    chk("t5_rdk_hi", rdk, 32'h0);
    chk("t5_rd_errk", 32'(ek), 32'd1);
`else
    chk("t5_rdk_hi", rdk, 32'hA5A5A5A5);
    chk("t5_rd_errk", 32'(ek), 32'd0);
`endif
    chk("t5_rd_err0", 32'(e0), 32'd0);

    // Reset in the middle of a 3-wait write
    wr(16'h0024, 32'h77777777, 4'hF);
    paddr = 16'h0024; pwrite = 1'b1; pstrb = 4'hF; pwdata = 32'h55555555;
    psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    chk("t6_rst_pready3", 32'(pready3), 32'd0);
    chk("t6_rst_prdata3", prdata3, 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    rd(16'h0024);
    chk("t6_rd3", rd3, 32'h77777777);
    chk("t6_lo3", 32'(lo3), 32'd3);
    chk("t6_rd0", rd0, 32'h55555555);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
